// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: width helpers,
// pointer typedef and flag reset constants.
package fifo_pkg;

    // Widest pointer any instance may use; a DEPTH of 2**31 is far beyond any real buffer.
    localparam int PTR_MAX_W = 32;

    // Pointer with the wrap bit as MSB; instances use only the low ADDR_W+1 bits.
    typedef logic [PTR_MAX_W-1:0] fifo_ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    localparam logic OVERFLOW_RST  = 1'b0;
    localparam logic UNDERFLOW_RST = 1'b0;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy spans 0..DEPTH, so one bit more than the address.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered,
// enabled read port. The array itself is not reset so it maps onto block RAM.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost-full/empty thresholds and a read-valid strobe.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          err_clr
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = count_width(DEPTH);

    logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    fifo_flags_t      flags_reg, flags_next;
    logic             rd_valid_reg;
    logic             wr_accept;
    logic             rd_accept;
    fifo_ptr_t        wr_ptr_view;
    fifo_ptr_t        rd_ptr_view;

    // Gating uses only the registered flags, so no enable reaches an output combinationally.
    assign wr_accept = wr_en && !flags_reg.full;
    assign rd_accept = rd_en && !flags_reg.empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{ADDR_W{1'b0}}, wr_accept};
        rd_ptr_next = rd_ptr_reg + {{ADDR_W{1'b0}}, rd_accept};
    end

    // Flags and count are precomputed from the next pointers and registered,
    // so every status output comes straight from a flop.
    always_comb begin
        count_next              = wr_ptr_next - rd_ptr_next;
        flags_next              = FLAGS_RST;
        flags_next.full         = (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                                  (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
        flags_next.empty        = (wr_ptr_next == rd_ptr_next);
        flags_next.almost_full  = (count_next >= CNT_W'(AF_LEVEL));
        flags_next.almost_empty = (count_next <= CNT_W'(AE_LEVEL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            flags_reg    <= FLAGS_RST;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            flags_reg    <= flags_next;
            rd_valid_reg <= rd_accept;
        end
    end

    // Full and empty never coincide, so the two ports never address the same entry in one cycle.
    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_accept),
        .waddr(wr_ptr_reg[ADDR_W-1:0]),
        .wdata(data_in),
        .re   (rd_accept),
        .raddr(rd_ptr_reg[ADDR_W-1:0]),
        .rdata(data_out)
    );

    assign wr_ptr_view = fifo_ptr_t'(wr_ptr_reg);
    assign rd_ptr_view = fifo_ptr_t'(rd_ptr_reg);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // A new error takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= OVERFLOW_RST;
            underflow_reg <= UNDERFLOW_RST;
        end else begin
            if (wr_en && flags_reg.full) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (rd_en && flags_reg.empty) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    logic unused_err;
    assign unused_err = ^{wr_ptr_view, rd_ptr_view};
`else
    assign overflow  = OVERFLOW_RST;
    assign underflow = UNDERFLOW_RST;

    logic unused_err;
    assign unused_err = ^{err_clr, wr_ptr_view, rd_ptr_view};
`endif

    assign rd_valid     = rd_valid_reg;
    assign count        = count_reg;
    assign full         = flags_reg.full;
    assign empty        = flags_reg.empty;
    assign almost_full  = flags_reg.almost_full;
    assign almost_empty = flags_reg.almost_empty;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16); error-flag
// expectations follow SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    int num_checks;
    int num_errors;

    logic [WIDTH-1:0] exp_q[$];
    int               m_cnt;
    logic [WIDTH-1:0] m_last;
    logic             m_ov;
    logic             m_un;
    logic [WIDTH-1:0] next_byte;

    sync_fifo_param #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(DEPTH - 2),
        .AE_LEVEL(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= DEPTH - 2));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
        chk("data_out", 32'(data_out), 32'(m_last));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
    endtask

    // One clock of stimulus; the reference model decides acceptance from its own occupancy.
    task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re, input logic clr);
        logic w_acc, r_acc, ov_set, un_set;
        logic [WIDTH-1:0] exp_d;
        @(negedge clk);
        wr_en   = we;
        data_in = wd;
        rd_en   = re;
        err_clr = clr;
        w_acc   = we && (m_cnt != DEPTH);
        r_acc   = re && (m_cnt != 0);
        ov_set  = we && (m_cnt == DEPTH);
        un_set  = re && (m_cnt == 0);
        @(posedge clk);
        #1;
        if (w_acc) exp_q.push_back(wd);
        if (r_acc) begin
            exp_d  = exp_q.pop_front();
            m_last = exp_d;
        end
        m_cnt = m_cnt + int'(w_acc) - int'(r_acc);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        m_ov = ov_set | (m_ov & ~clr);
        m_un = un_set | (m_un & ~clr);
`else
        m_ov = 1'b0;
        m_un = 1'b0;
        if (ov_set || un_set) m_ov = 1'b0;
`endif
        $display("cyc we=%0b wd=%02h re=%0b clr=%0b -> cnt=%0d rv=%0b dout=%02h", we, wd, re, clr, count, rd_valid, data_out);
        chk("rd_valid", 32'(rd_valid), 32'(r_acc));
        check_status();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic write_word();
        step(1'b1, next_byte, 1'b0, 1'b0);
        next_byte = next_byte + 8'd1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH && m_cnt > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_last = '0;
        m_ov   = 1'b0;
        m_un   = 1'b0;
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        next_byte  = 8'h00;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        err_clr    = 1'b0;
        data_in    = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x00..0x0F, then full edge with simultaneous read/write.
        for (int i = 0; i < DEPTH; i++) begin
            write_word();
            if (m_cnt == DEPTH - 2) chk("af_at_14", 32'(almost_full), 32'd1);
        end
        chk("full_after_16", 32'(full), 32'd1);
        chk("count_16", 32'(count), 32'(DEPTH));
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_edge_count", 32'(count), 32'(DEPTH - 1));
        chk("full_edge_dout", 32'(data_out), 32'h00);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("full_edge_ovf", 32'(overflow), 32'd1);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();
        chk("empty_after_drain", 32'(empty), 32'd1);
        chk("last_drained", 32'(data_out), 32'h0F);

        // Simultaneous access at count=5.
        next_byte = 8'h40;
        repeat (5) write_word();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, next_byte, 1'b1, 1'b0);
            next_byte = next_byte + 8'd1;
            chk("simul_count5", 32'(count), 32'd5);
        end
        drain();

        // Simultaneous access at empty: write accepted, read rejected.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("simul_empty_count", 32'(count), 32'd1);
        chk("simul_empty_rv", 32'(rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("unf_held", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_cleared", 32'(underflow), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("unf_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Random interleaved bursts with wrap-around.
        for (int b = 0; b < 40; b++) begin
            int wl, rl;
            wl = int'($urandom_range(DEPTH, 1));
            rl = int'($urandom_range(DEPTH, 1));
            for (int i = 0; i < wl; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
            for (int i = 0; i < rl; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        drain();

        // Reset mid-stream after five writes and one read.
        next_byte = 8'hC1;
        repeat (5) write_word();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_dout", 32'(data_out), 32'd0);
        check_status();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_read_rej", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that replaces the fixed 8-bit, hard-coded-depth synchronous FIFO in the datapath buffering layer. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, a read-valid strobe, and optional sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, and each side uses a simple enable handshake.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL; range 1..DEPTH-1.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL; range 1..DEPTH-1.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `data_in`  in  WIDTH  write data, sampled when a write is accepted.
- `rd_en`  in  1  read request.
- `data_out`  out  WIDTH  registered read data.
- `rd_valid`  out  1  one-cycle pulse; `data_out` is valid for this read.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.
- `err_clr`  in  1  synchronous clear of `overflow` and `underflow`.

## Operation
- Pointers:
  - Write and read pointers are ADDR_W+1 bits, where ADDR_W = $clog2(DEPTH). The MSB is the wrap bit.
  - Each pointer increments by 1 per accepted access and wraps naturally modulo 2·DEPTH.
  - count = wr_ptr − rd_ptr, computed in ADDR_W+1-bit arithmetic.
  - full is asserted when the wrap bits differ and the address bits are equal. empty is asserted when the full pointers are equal.
- Acceptance:
  - A write is accepted when `wr_en && !full`. The memory entry at wr_ptr[ADDR_W-1:0] is written and wr_ptr is incremented.
  - A read is accepted when `rd_en && !empty`. data_out is loaded from rd_ptr[ADDR_W-1:0], rd_ptr is incremented, and rd_valid is pulsed.
  - Gating uses the flags from the current cycle only. When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
- Rejected accesses:
  - A rejected access changes no pointer, memory entry, or data_out.
  - data_out holds its last value when no read is accepted.
- Reset:
  - While rst_n is low: both pointers 0, data_out 0, rd_valid 0, full 0, empty 1, almost_full 0, almost_empty 1, count 0, overflow 0, underflow 0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write-to-read latency:
  - A word written at edge N makes empty deassert after edge N.
  - The earliest accepting read is at edge N+1.
  - Its data appears on data_out, with rd_valid high, after edge N+1.
- Read latency: 1 cycle from the accepting edge to data_out and rd_valid.
- Flags and count:
  - All flags and count derive only from registered pointers, so they are glitch-free.
  - They reflect the accesses accepted at the most recent edge.
- There is no combinational path from wr_en or rd_en to any output.

## Configuration
- Controlled by macro `SYNC_FIFO_ERR_FLAGS_EN`.
- When defined:
  - overflow is set on any cycle with `wr_en && full`.
  - underflow is set on any cycle with `rd_en && empty`.
  - Both stay set until err_clr is sampled high.
  - If err_clr and a new error occur in the same cycle, the set wins.
- When undefined:
  - overflow and underflow are tied to 0 and err_clr is ignored.
  - Ports remain, so the interface stays stable.

## Structure
- Package `fifo_pkg` holds the shared items:
  - the function computing the count width from DEPTH;
  - a typedef for the pointer-with-wrap-bit;
  - the reset constants for the flags.
- Sub-module `fifo_ram_2p` contains the DEPTH×WIDTH storage:
  - one synchronous write port;
  - one registered synchronous read port with an enable.
- The top level contains the pointers, flags, count, and error logic.

## Test plan
- Reset: drive rst_n low mid-stream after 5 writes → immediately empty=1, count=0, data_out=0; after release, the first read is rejected.
- Fill/drain (WIDTH=8, DEPTH=16):
  - Write 0x00..0x0F → full=1 after the 16th write; count=16; almost_full asserted from count=14.
  - Read 16 times → 0x00..0x0F in order, each with rd_valid; empty=1 after the last read.
- Wrap-around: 40 interleaved write/read bursts of random length ≤ DEPTH → output sequence equals input sequence; count always equals the reference-model occupancy.
- Simultaneous access at count=5: rd_en=wr_en=1 for 10 cycles → count stays 5 and data order is preserved. Repeat at empty: write accepted, read rejected, count=1.
- Full edge: at full, rd_en=wr_en=1 → read accepted, write rejected, count=15, written data not stored. With the macro defined, overflow=1.
- Error flags (macro defined): read while empty → underflow=1 and held. err_clr=1 → both cleared the next cycle. err_clr coinciding with a new error → flag remains 1.
